// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - FSM state type and width helpers shared by popcount_scheduler
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_id_w(input int nreq);
    int w;
    w = $clog2(nreq);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/popcount_scheduler_if.sv
// rtl/popcount_scheduler_if.sv - request/response bundle between requesters, consumer and popcount_scheduler
interface popcount_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  import popcount_pkg::*;

  localparam int ID_W  = calc_id_w(NREQ);
  localparam int CNT_W = calc_cnt_w(WIDTH);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [CNT_W-1:0]      rsp_count;
  logic                  rsp_ready;
  logic                  busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_count, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_count, busy
  );

endinterface

// File: rtl/popcount_arbiter.sv
// rtl/popcount_arbiter.sv - one-hot grant for the shared engine
// POPCOUNT_SCHED_RR_EN selects round-robin; otherwise fixed priority, lowest index wins.
module popcount_arbiter import popcount_pkg::*; #(
  parameter int NREQ = 4,
  parameter int ID_W = calc_id_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx
);

  logic found;

`ifdef POPCOUNT_SCHED_RR_EN
  logic [ID_W-1:0] ptr;
  int              cand;

  // Search begins just past the last granted index so every requester gets a turn.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(ptr) + off) % NREQ;
      if (enable && !found && req[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = ID_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= ID_W'(NREQ - 1);
    end else if (accept) begin
      ptr <= grant_idx;
    end
  end
`else
  logic unused_fixed;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (enable && !found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end

  // No pointer state in this build, so clock, reset and accept go unused.
  assign unused_fixed = &{1'b0, clk, rst, accept};
`endif

endmodule

// File: rtl/popcount_scheduler.sv
// rtl/popcount_scheduler.sv - one iterative popcount engine shared among NREQ requesters
// Arbitration style chosen by POPCOUNT_SCHED_RR_EN inside popcount_arbiter.
module popcount_scheduler import popcount_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                clk,
  input  logic                rst,
  popcount_scheduler_if.slave bus
);

  localparam int ID_W  = calc_id_w(NREQ);
  localparam int CNT_W = calc_cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  id;

  logic             arb_enable;
  logic             accept;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] sel_data;

  // Grants are masked while reset is high so req_ready reads 0 during reset.
  assign arb_enable = (state == IDLE) && !rst;
  assign accept     = |grant;
  assign sel_data   = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];

  popcount_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .enable    (arb_enable),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work  <= sel_data;
            cnt   <= '0;
            id    <= grant_idx;
            state <= RUN;
          end
        end
        RUN: begin
          // Clearing the lowest set bit each cycle bounds cnt by WIDTH.
          if (work != '0) begin
            work <= work & (work - WIDTH'(1));
            cnt  <= cnt + CNT_W'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_id    = id;
  assign bus.rsp_count = cnt;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_popcount_scheduler.sv
// tb/tb_popcount_scheduler.sv - randomized self-checking bench for popcount_scheduler
module tb_popcount_scheduler;

  localparam int W         = 8;
  localparam int N         = 4;
  localparam int LAT_MAX   = W + 4;
  localparam int GRANT_MAX = 200;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   last_grant  = N - 1;

  popcount_scheduler_if #(.WIDTH(W), .NREQ(N)) bus ();

  popcount_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int ref_count(input logic [W-1:0] d);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) if (d[i]) c = c + 1;
    return c;
  endfunction

  function automatic int ref_winner(input logic [N-1:0] v, input int last);
`ifdef POPCOUNT_SCHED_RR_EN
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`else
    if (last >= N) return -1;
    for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_grant = N - 1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d);
    bus.req_data[i*W +: W] = d;
    bus.req_valid[i]       = 1'b1;
  endtask

  function automatic logic [W-1:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic expect_job(input string tag, input bit drop, output int winner);
    bit           got;
    int           lat, exp_k, exp_w;
    logic [W-1:0] d;
    logic [N-1:0] onehot;
    logic [1:0]   exp_id;
    logic [3:0]   exp_cnt;
    got    = 1'b0;
    winner = -1;
    #1;
    for (int c = 0; c < GRANT_MAX && !got; c++) begin
      if (|bus.req_ready) got = 1'b1;
      else tick();
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s grant_timeout: req_ready=%b required a grant for req_valid=%b", tag, bus.req_ready, bus.req_valid);
      return;
    end
    for (int i = N - 1; i >= 0; i--) if (bus.req_ready[i]) winner = i;
    exp_w  = ref_winner(bus.req_valid, last_grant);
    onehot = '0;
    if (exp_w >= 0) onehot[exp_w] = 1'b1;
    else exp_w = 0;
    vectors++;
    if (bus.req_ready !== onehot) begin
      miscompares++;
      $display("FAIL %s grant: req_ready=%b required %b", tag, bus.req_ready, onehot);
    end
    d       = bus.req_data[exp_w*W +: W];
    exp_k   = ref_count(d);
    exp_id  = exp_w[1:0];
    exp_cnt = exp_k[3:0];
    tick();
    last_grant = exp_w;
    if (drop) bus.req_valid[exp_w] = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_accept: busy=%b required 1", tag, bus.busy);
    end
    lat = 0;
    for (int c = 1; c <= LAT_MAX && lat == 0; c++) begin
      tick();
      if (bus.rsp_valid === 1'b1) lat = c;
    end
    vectors++;
    if (lat != exp_k + 1) begin
      miscompares++;
      $display("FAIL %s latency: rsp_valid after %0d cycles required %0d (data=%h)", tag, lat, exp_k + 1, d);
    end
    if (lat == 0) return;
    vectors++;
    if (bus.rsp_id !== exp_id) begin
      miscompares++;
      $display("FAIL %s rsp_id: got %0d required %0d", tag, bus.rsp_id, exp_id);
    end
    vectors++;
    if (bus.rsp_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL %s rsp_count: got %0d required %0d (data=%h)", tag, bus.rsp_count, exp_cnt, d);
    end
    if (bus.rsp_ready) begin
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s after_handshake: rsp_valid=%b busy=%b required 0 0", tag, bus.rsp_valid, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.req_valid  = '1;
    bus.req_data   = $urandom;
    bus.rsp_ready  = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b busy=%b required 0", bus.req_ready, bus.rsp_valid, bus.busy);
    end
    vectors++;
    if (bus.rsp_id !== '0 || bus.rsp_count !== '0) begin
      miscompares++;
      $display("FAIL reset_data: rsp_id=%0d rsp_count=%0d required 0 0", bus.rsp_id, bus.rsp_count);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    last_grant = N - 1;
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_single_jobs();
    int w;
    set_req(0, 8'hB4);
    expect_job("single_b4", 1'b1, w);
    set_req(2, 8'h00);
    expect_job("single_zero", 1'b1, w);
    set_req(1, 8'hFF);
    expect_job("single_ones", 1'b1, w);
  endtask

  task automatic test_arbitration();
    int seq [5];
    int w;
`ifdef POPCOUNT_SCHED_RR_EN
    seq = '{0, 1, 2, 3, 0};
`else
    seq = '{0, 0, 0, 0, 0};
`endif
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, W'($urandom_range(0, 255)));
    for (int j = 0; j < 5; j++) begin
      expect_job("arb", 1'b0, w);
      vectors++;
      if (w != seq[j]) begin
        miscompares++;
        $display("FAIL arb_sequence[%0d]: granted %0d required %0d", j, w, seq[j]);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    int           w;
    logic [W-1:0] d1;
    logic [1:0]   exp_id;
    logic [3:0]   exp_cnt;
    apply_reset();
    bus.rsp_ready = 1'b0;
    d1 = W'($urandom_range(0, 255));
    set_req(1, d1);
    expect_job("bp", 1'b1, w);
    set_req(3, pick_data());
    exp_id  = 2'd1;
    exp_cnt = 4'(ref_count(d1));
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id || bus.rsp_count !== exp_cnt ||
          bus.req_ready !== '0 || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b id=%0d count=%0d req_ready=%b busy=%b required 1 %0d %0d 0000 1",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.req_ready, bus.busy, exp_id, exp_cnt);
      end
    end
    bus.rsp_ready = 1'b1;
    tick();
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: rsp_valid=%b required 0", bus.rsp_valid);
    end
    expect_job("bp_next", 1'b1, w);
  endtask

  task automatic test_reset_mid_run();
    int w;
    bit seen;
    apply_reset();
    set_req(0, 8'hF0);
    expect_job("pre_rst_pipe", 1'b1, w);
    set_req(0, 8'hF0);
    #1;
    for (int c = 0; c < GRANT_MAX && bus.req_ready[0] !== 1'b1; c++) tick();
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    tick();
    set_req(2, W'($urandom_range(0, 255)));
    bus.req_valid[0] = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_busy: busy=%b required 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.rsp_id !== '0 || bus.rsp_count !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: req_ready=%b valid=%b busy=%b id=%0d count=%0d required all 0",
               bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_count);
    end
    tick();
    rst = 1'b0;
    last_grant = N - 1;
    bus.req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < LAT_MAX + 4; c++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL rst_mid_dropped: response or busy seen after reset, required none");
    end
    set_req(2, W'($urandom_range(0, 255)));
    set_req(0, 8'hF0);
    expect_job("rst_next", 1'b1, w);
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL rst_next_winner: granted %0d required 0", w);
    end
    expect_job("rst_drain", 1'b1, w);
  endtask

  task automatic test_busy_hold();
    int w;
    bit leaked;
    apply_reset();
    set_req(0, W'($urandom_range(1, 255)));
    #1;
    for (int c = 0; c < GRANT_MAX && bus.req_ready[0] !== 1'b1; c++) tick();
    tick();
    bus.req_valid[0] = 1'b0;
    last_grant = 0;
    set_req(3, pick_data());
    #1;
    leaked = 1'b0;
    for (int c = 0; c < LAT_MAX + 4 && bus.busy === 1'b1; c++) begin
      if (bus.req_ready !== '0) leaked = 1'b1;
      tick();
    end
    vectors++;
    if (leaked || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_hold: req_ready raised while busy or engine stuck (busy=%b), required held low then idle", bus.busy);
    end
    expect_job("busy_next", 1'b1, w);
    vectors++;
    if (w != 3) begin
      miscompares++;
      $display("FAIL busy_next_winner: granted %0d required 3", w);
    end
  endtask

  task automatic test_random();
    int w;
    int stall;
    apply_reset();
    bus.req_valid = '0;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, pick_data());
      if (bus.req_valid == '0) set_req(int'($urandom_range(0, N - 1)), pick_data());
      bus.rsp_ready = 1'($urandom_range(0, 1));
      expect_job("random", 1'b1, w);
      if (!bus.rsp_ready) begin
        stall = int'($urandom_range(0, 3));
        for (int s = 0; s < stall; s++) begin
          tick();
          vectors++;
          if (bus.rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL random_stall: rsp_valid=%b required 1", bus.rsp_valid);
          end
        end
        bus.rsp_ready = 1'b1;
        tick();
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL random_release: rsp_valid=%b required 0", bus.rsp_valid);
        end
      end
    end
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_jobs();
    test_arbitration();
    test_backpressure();
    test_reset_mid_run();
    test_busy_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/popcount_scheduler.md
# popcount_scheduler

Shares one iterative set-bit-count engine among NREQ requesters. Arbitrates pending requests, captures the winner's operand and counts its set bits one per cycle with the clear-lowest-set-bit step (w <= w & (w-1)). Returns the count tagged with the requester index over a valid/ready response channel. It is the sequencing front end for any block that needs occasional popcounts without spending a full adder tree per requester.

## Interface
- WIDTH, 8: operand width in bits, ≥1
- NREQ, 4: number of requesters, ≥2
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept; at most one bit high
- rsp_valid  out  1  result available
- rsp_id  out  ID_W = max(1,$clog2(NREQ))  index of the served requester
- rsp_count  out  CNT_W = $clog2(WIDTH+1)  number of set bits
- rsp_ready  in  1  consumer accepts the result
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req_valid is high, req_ready is driven high (combinationally) for the arbitration winner only.
  - At the edge: work <= winner's data, cnt <= 0, id <= winner, state -> RUN.
  - If no req_valid is high, remain in IDLE.
- RUN:
  - If work != 0: work <= work & (work-1), cnt <= cnt+1, stay in RUN.
  - If work == 0: state -> DONE.
- DONE:
  - rsp_valid = 1; rsp_id and rsp_count are held stable.
  - On rsp_valid & rsp_ready: state -> IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- req_ready is low in RUN and DONE.
- Requesters must hold req_valid and req_data stable until they see req_ready; a request may not be withdrawn before it is accepted.
- cnt never exceeds WIDTH, so it cannot overflow CNT_W.
- Arbitration:
  - A priority pointer holds the last granted index.
  - The search starts at pointer+1 and wraps modulo NREQ.
  - The pointer updates only on accept.

## Timing
- Accept at edge T, operand with k set bits: rsp_valid rises after edge T+k+1.
  - Zero operand: rsp_valid rises after edge T+1.
  - All-ones operand: rsp_valid rises after edge T+WIDTH+1.
- Minimum occupancy per job is k+3 cycles (accept, k+1 RUN cycles, DONE with rsp_ready high).
- rsp_ready held low: DONE persists indefinitely and outputs are frozen.
- Reset values: state IDLE, work 0, cnt 0, id 0, pointer NREQ-1 (so requester 0 wins first). All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_count, busy.
- Reset asserted mid-RUN or mid-DONE:
  - Outputs clear immediately (asynchronously).
  - The job in flight is dropped and no response is produced after release.
- A request that stays valid while the engine is busy is served later. It is never lost.

## Configuration
- POPCOUNT_SCHED_RR_EN defined: round-robin arbitration as described above.
- POPCOUNT_SCHED_RR_EN undefined: fixed priority, lowest index wins.
  - The pointer register is not built.
  - The rest of the behaviour is identical.

## Structure
- Package popcount_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - functions computing ID_W and CNT_W from NREQ and WIDTH
- Sub-module popcount_arbiter:
  - inputs: request vector, enable (state == IDLE), accept strobe
  - outputs: one-hot grant and encoded index
  - owns the pointer and the POPCOUNT_SCHED_RR_EN choice
- Top level holds the FSM, the work and cnt registers, and the response registers.

## Test plan
- Requester 0 with data 8'hB4, rsp_ready=1 -> rsp_valid 5 cycles after accept, rsp_count=4, rsp_id=0.
- Requester 2 with data 8'h00 -> rsp_count=0, rsp_id=2, rsp_valid 1 cycle after accept. Requester 1 with 8'hFF -> rsp_count=8, rsp_valid 9 cycles after accept.
- All four requesters valid continuously, rsp_ready=1 -> with POPCOUNT_SCHED_RR_EN, rsp_id sequence 0,1,2,3,0. Without it, 0,0,0.
- rsp_ready held low for 10 cycles in DONE -> rsp_valid, rsp_id and rsp_count stable, req_ready all 0, busy=1. One response is delivered when rsp_ready rises.
- rst pulsed 2 cycles into a RUN on data 8'hF0 -> all outputs 0 immediately, no rsp_valid after release, next accept goes to requester 0.
- Requester 3 valid while the engine is busy on requester 0 -> req_ready[3] stays low until IDLE. It is then accepted and its correct count is returned.
